addacc_tcount_bank: RTL and testbench

Parametrised, clocked successor of the single-bit T1 accumulator cell: a bank of CHANNELS independent toggle accumulators, each CNT_W bits wide, with destructive read-and-clear, carry-out, and cycle-based separation and hold/setup checking. It sits in the adder/accumulator datapath wherever several T1 cells or T1 chains are read out together. Timing violations are reported as error flags rather than X states.

---
 rtl/addacc_tcount_bank.sv | 196 +++++++++++++++++++
 tb/tb_addacc_tcount_bank.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/addacc_tcount_bank.sv
// addacc_tcount_bank: bank of independent toggle accumulators with
// destructive read-and-clear, carry-out and cycle-based timing checks.
//
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   t[c]           increment strobe for channel c
//   wr0[c]         read-and-clear strobe for channel c
//   out[c]         one-cycle carry pulse (registered)
//   rd_valid[c]    one-cycle readout strobe, RD_LAT cycles after wr0
//   rd_data        readout values, channel c at [c*CNT_W +: CNT_W]
//   rd_err[c]      readout invalid flag, qualified by rd_valid
//   viol_sep[c]    t-to-t separation violation pulse (registered)
//   viol_hs[c]     t-after-wr0 hold/setup violation pulse (registered)

module addacc_tcount_bank #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 4,
    parameter int SEP_CYC  = 3,
    parameter int HS_CYC   = 2,
    parameter int RD_LAT   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       t,
    input  logic [CHANNELS-1:0]       wr0,
    output logic [CHANNELS-1:0]       out,
    output logic [CHANNELS-1:0]       rd_valid,
    output logic [CHANNELS*CNT_W-1:0] rd_data,
    output logic [CHANNELS-1:0]       rd_err,
    output logic [CHANNELS-1:0]       viol_sep,
    output logic [CHANNELS-1:0]       viol_hs
);

    localparam int SW = (SEP_CYC > 1) ? $clog2(SEP_CYC) : 1;
    localparam int HW = (HS_CYC > 1) ? $clog2(HS_CYC) : 1;

    // Per-channel accumulator and poison
    logic [CNT_W-1:0]    cnt_q    [CHANNELS];
    logic [CNT_W-1:0]    cnt_d    [CHANNELS];
    logic [CHANNELS-1:0] poison_q;
    logic [CHANNELS-1:0] poison_d;

    // Window down-counters: separation copy and hold/setup copy for t,
    // plus hold/setup window opened by wr0
    logic [SW-1:0] tsep_q [CHANNELS];
    logic [SW-1:0] tsep_d [CHANNELS];
    logic [HW-1:0] ths_q  [CHANNELS];
    logic [HW-1:0] ths_d  [CHANNELS];
    logic [HW-1:0] wage_q [CHANNELS];
    logic [HW-1:0] wage_d [CHANNELS];

    // Registered pulse outputs
    logic [CHANNELS-1:0] out_q;
    logic [CHANNELS-1:0] out_d;
    logic [CHANNELS-1:0] vsep_q;
    logic [CHANNELS-1:0] vsep_d;
    logic [CHANNELS-1:0] vhs_q;
    logic [CHANNELS-1:0] vhs_d;

    // Readout pipeline; the last stage drives the outputs directly
    logic             pv_q [CHANNELS][RD_LAT];
    logic             pv_d [CHANNELS][RD_LAT];
    logic [CNT_W-1:0] pd_q [CHANNELS][RD_LAT];
    logic [CNT_W-1:0] pd_d [CHANNELS][RD_LAT];
    logic             pe_q [CHANNELS][RD_LAT];
    logic             pe_d [CHANNELS][RD_LAT];

    // Capture request into pipeline stage 0
    logic [CHANNELS-1:0] cap_v;
    logic [CHANNELS-1:0] cap_e;
    logic [CHANNELS-1:0] t_only;
    logic [CHANNELS-1:0] w_only;
    logic [CHANNELS-1:0] t_and_w;
    logic [CHANNELS-1:0] sep_hit;
    logic [CHANNELS-1:0] hs_hit;
    logic [CHANNELS-1:0] conf_hit;

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            cnt_d[c]    = cnt_q[c];
            poison_d[c] = poison_q[c];
            out_d[c]    = 1'b0;
            vsep_d[c]   = 1'b0;
            vhs_d[c]    = 1'b0;
            cap_v[c]    = 1'b0;
            cap_e[c]    = 1'b0;

            t_only[c]   = t[c] & ~wr0[c];
            w_only[c]   = wr0[c] & ~t[c];
            t_and_w[c]  = t[c] & wr0[c];
            sep_hit[c]  = (tsep_q[c] != '0);
            hs_hit[c]   = (wage_q[c] != '0);
            conf_hit[c] = (ths_q[c] != '0);

            tsep_d[c] = sep_hit[c] ? tsep_q[c] - 1'b1 : '0;
            ths_d[c]  = conf_hit[c] ? ths_q[c] - 1'b1 : '0;
            wage_d[c] = hs_hit[c] ? wage_q[c] - 1'b1 : '0;

            // Every t pulse opens its windows, even a conflicting one,
            // so spacing is always measured from the last t seen.
            if (t[c]) begin
                tsep_d[c] = SW'(SEP_CYC - 1);
                ths_d[c]  = HW'(HS_CYC - 1);
            end
            if (wr0[c]) begin
                wage_d[c] = HW'(HS_CYC - 1);
            end

            if (t_only[c]) begin
                cnt_d[c]  = cnt_q[c] + 1'b1;
                out_d[c]  = &cnt_q[c];
                vsep_d[c] = sep_hit[c];
                vhs_d[c]  = hs_hit[c];
                if (sep_hit[c] || hs_hit[c]) begin
                    poison_d[c] = 1'b1;
                end
            end else if (w_only[c]) begin
                cap_v[c]    = 1'b1;
                cap_e[c]    = poison_q[c] | conf_hit[c];
                cnt_d[c]    = '0;
                poison_d[c] = conf_hit[c];
            end else if (t_and_w[c]) begin
                cap_v[c]    = 1'b1;
                cap_e[c]    = 1'b1;
                cnt_d[c]    = '0;
                poison_d[c] = 1'b1;
            end

            // Data/err hold their value unless a valid entry moves in,
            // which gives rd_data its hold-last-value behaviour.
            pv_d[c][0] = cap_v[c];
            pd_d[c][0] = pd_q[c][0];
            pe_d[c][0] = pe_q[c][0];
            if (cap_v[c]) begin
                pd_d[c][0] = cnt_q[c];
                pe_d[c][0] = cap_e[c];
            end
            for (int s = 1; s < RD_LAT; s++) begin
                pv_d[c][s] = pv_q[c][s-1];
                pd_d[c][s] = pd_q[c][s];
                pe_d[c][s] = pe_q[c][s];
                if (pv_q[c][s-1]) begin
                    pd_d[c][s] = pd_q[c][s-1];
                    pe_d[c][s] = pe_q[c][s-1];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            poison_q <= '0;
            out_q    <= '0;
            vsep_q   <= '0;
            vhs_q    <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                cnt_q[c]  <= '0;
                tsep_q[c] <= '0;
                ths_q[c]  <= '0;
                wage_q[c] <= '0;
                for (int s = 0; s < RD_LAT; s++) begin
                    pv_q[c][s] <= 1'b0;
                    pd_q[c][s] <= '0;
                    pe_q[c][s] <= 1'b0;
                end
            end
        end else begin
            poison_q <= poison_d;
            out_q    <= out_d;
            vsep_q   <= vsep_d;
            vhs_q    <= vhs_d;
            for (int c = 0; c < CHANNELS; c++) begin
                cnt_q[c]  <= cnt_d[c];
                tsep_q[c] <= tsep_d[c];
                ths_q[c]  <= ths_d[c];
                wage_q[c] <= wage_d[c];
                for (int s = 0; s < RD_LAT; s++) begin
                    pv_q[c][s] <= pv_d[c][s];
                    pd_q[c][s] <= pd_d[c][s];
                    pe_q[c][s] <= pe_d[c][s];
                end
            end
        end
    end

    assign out      = out_q;
    assign viol_sep = vsep_q;
    assign viol_hs  = vhs_q;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_rd
        assign rd_valid[c]                 = pv_q[c][RD_LAT-1];
        assign rd_err[c]                   = pe_q[c][RD_LAT-1];
        assign rd_data[c*CNT_W +: CNT_W]   = pd_q[c][RD_LAT-1];
    end

endmodule

// File: tb/tb_addacc_tcount_bank.sv
// Testbench for addacc_tcount_bank: directed scenarios plus random
// traffic checked against a timestamp-based reference model.

module tb_addacc_tcount_bank;

    localparam int CH  = 4;
    localparam int CW  = 4;
    localparam int SEP = 3;
    localparam int HS  = 2;
    localparam int LAT = 2;

    logic          clk;
    logic          rst;
    logic [CH-1:0] t;
    logic [CH-1:0] wr0;
    logic [CH-1:0] out;
    logic [CH-1:0] rd_valid;
    logic [CH*CW-1:0] rd_data;
    logic [CH-1:0] rd_err;
    logic [CH-1:0] viol_sep;
    logic [CH-1:0] viol_hs;

    addacc_tcount_bank #(
        .CHANNELS(CH), .CNT_W(CW), .SEP_CYC(SEP), .HS_CYC(HS), .RD_LAT(LAT)
    ) dut (
        .clk(clk), .rst(rst), .t(t), .wr0(wr0), .out(out),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err),
        .viol_sep(viol_sep), .viol_hs(viol_hs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: event timestamps instead of window counters
    typedef struct {
        int due;
        int ch;
        int data;
        bit err;
    } rd_t;

    rd_t q[$];
    int  cyc_n;
    int  last_t [CH];
    int  last_w [CH];
    int  m_cnt  [CH];
    bit  m_pois [CH];
    int  held   [CH];
    logic [CH-1:0] e_out, e_sep, e_hs, e_v, e_err;
    logic [CH*CW-1:0] e_data;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d",
                   tag, obs, exp, cyc_n);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int c = 0; c < CH; c++) begin
            last_t[c] = -1000;
            last_w[c] = -1000;
            m_cnt[c]  = 0;
            m_pois[c] = 0;
            held[c]   = 0;
        end
    endtask

    task automatic model_step(input logic [CH-1:0] tv,
                              input logic [CH-1:0] wv);
        rd_t e;
        bit  sep, hs, conf;
        e_out = '0;
        e_sep = '0;
        e_hs  = '0;
        for (int c = 0; c < CH; c++) begin
            if (tv[c] && !wv[c]) begin
                sep = (cyc_n - last_t[c]) < SEP;
                hs  = (cyc_n - last_w[c]) < HS;
                e_out[c] = (m_cnt[c] == (1 << CW) - 1);
                e_sep[c] = sep;
                e_hs[c]  = hs;
                m_cnt[c] = (m_cnt[c] + 1) % (1 << CW);
                if (sep || hs) m_pois[c] = 1;
            end else if (wv[c]) begin
                conf   = tv[c] || ((cyc_n - last_t[c]) < HS);
                e.due  = cyc_n + LAT;
                e.ch   = c;
                e.data = m_cnt[c];
                e.err  = m_pois[c] || conf;
                q.push_back(e);
                m_cnt[c]  = 0;
                m_pois[c] = conf;
            end
            if (tv[c]) last_t[c] = cyc_n;
            if (wv[c]) last_w[c] = cyc_n;
        end
    endtask

    task automatic model_outputs();
        e_v   = '0;
        e_err = '0;
        while (q.size() > 0 && q[0].due == cyc_n) begin
            e_v[q[0].ch]   = 1'b1;
            e_err[q[0].ch] = q[0].err;
            held[q[0].ch]  = q[0].data;
            void'(q.pop_front());
        end
        for (int c = 0; c < CH; c++) e_data[c*CW +: CW] = CW'(held[c]);
    endtask

    task automatic tick(input logic [CH-1:0] tv, input logic [CH-1:0] wv);
        t   = tv;
        wr0 = wv;
        model_step(tv, wv);
        @(posedge clk);
        #1;
        cyc_n++;
        model_outputs();
        chk("out", 32'(out), 32'(e_out));
        chk("viol_sep", 32'(viol_sep), 32'(e_sep));
        chk("viol_hs", 32'(viol_hs), 32'(e_hs));
        chk("rd_valid", 32'(rd_valid), 32'(e_v));
        chk("rd_err", 32'(rd_err & rd_valid), 32'(e_err & e_v));
        chk("rd_data", 32'(rd_data), 32'(e_data));
        t   = '0;
        wr0 = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick('0, '0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_out"}, 32'(out), 0);
        chk({tag, "_rd_valid"}, 32'(rd_valid), 0);
        chk({tag, "_rd_data"}, 32'(rd_data), 0);
        chk({tag, "_rd_err"}, 32'(rd_err), 0);
        chk({tag, "_viol"}, 32'({viol_sep, viol_hs}), 0);
    endtask

    task automatic mid_reset();
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("rst_async");
        @(posedge clk);
        #1;
        cyc_n++;
        check_all_zero("rst_hold");
        rst = 1'b0;
        model_reset();
    endtask

    logic [CH-1:0] rt, rw;

    initial begin
        t     = '0;
        wr0   = '0;
        rst   = 1'b1;
        cyc_n = 0;
        model_reset();
        #1;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        cyc_n++;
        rst = 1'b0;

        // Basic count and readout on channel 0
        for (int i = 0; i < 5; i++) begin
            tick(4'b0001, '0);
            idle(3);
        end
        idle(2);
        tick('0, 4'b0001);
        idle(1);
        chk("basic_valid", 32'(rd_valid[0]), 1);
        chk("basic_data", 32'(rd_data[3:0]), 5);
        chk("basic_err", 32'(rd_err[0]), 0);
        idle(2);
        tick('0, 4'b0001);
        idle(1);
        chk("basic_data2", 32'(rd_data[3:0]), 0);

        // Wrap and carry on channel 2
        for (int i = 0; i < 16; i++) begin
            tick(4'b0100, '0);
            chk("carry2", 32'(out[2]), (i == 15) ? 1 : 0);
            idle(2);
        end
        idle(2);
        tick('0, 4'b0100);
        idle(1);
        chk("wrap_data", 32'(rd_data[11:8]), 0);

        // Separation violation on channel 1
        tick(4'b0010, '0);
        idle(1);
        tick(4'b0010, '0);
        chk("sep_pulse", 32'(viol_sep[1]), 1);
        idle(7);
        tick('0, 4'b0010);
        idle(1);
        chk("sep_data", 32'(rd_data[7:4]), 2);
        chk("sep_err", 32'(rd_err[1]), 1);
        idle(8);
        tick('0, 4'b0010);
        idle(1);

        // t then wr0 too close on channel 3
        tick(4'b1000, '0);
        tick('0, 4'b1000);
        idle(1);
        chk("tw_data", 32'(rd_data[15:12]), 1);
        chk("tw_err", 32'(rd_err[3]), 1);
        idle(7);
        tick('0, 4'b1000);
        idle(1);
        chk("tw_poison", 32'(rd_err[3]), 1);
        idle(8);
        tick('0, 4'b1000);
        idle(1);

        // wr0 then t too close, then same-cycle conflict, on channel 0
        tick('0, 4'b0001);
        tick(4'b0001, '0);
        chk("hs_pulse", 32'(viol_hs[0]), 1);
        idle(5);
        tick(4'b0001, 4'b0001);
        idle(1);
        chk("same_err", 32'(rd_err[0]), 1);
        chk("same_data", 32'(rd_data[3:0]), 1);
        idle(6);

        // Reset in the middle of a pending readout
        tick('0, 4'b0001);
        mid_reset();
        idle(4);
        tick(4'b0001, '0);
        idle(3);
        tick(4'b0001, '0);
        idle(5);
        tick('0, 4'b0001);
        idle(3);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            for (int c = 0; c < CH; c++) begin
                rt[c] = ($urandom_range(0, 99) < 30);
                rw[c] = ($urandom_range(0, 99) < 10);
            end
            tick(rt, rw);
        end
        idle(LAT + 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
